// File: rtl/alu_sequencer.sv
// Purpose: host-side initiator that queues ALU commands and runs the BEGIN/END handshake.
// Latency: from a command accepted into an empty FIFO, BEGIN is high 1 cycle later and the result is valid on the END edge.
// Backpressure: cmd_ready drops while the FIFO is full; a result is held in DONE until res_ready is high.
//
// Ports:
//   clk, resetn                      clock and asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_x/y/op   command input (valid/ready)
//   alu_x/alu_y/alu_op/alu_begin     operation issued to the ALU
//   alu_out/alu_end                  ALU result and completion strobe
//   res_valid/res_ready/res_data/res_op/res_timeout   result output (valid/ready)
//   busy                             work in flight or queued
//   proto_err                        sticky: END seen while no operation was being waited on
module alu_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [2:0]  alu_op,
  output logic        alu_begin,
  input  logic [15:0] alu_out,
  input  logic        alu_end,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_op,
  output logic        res_timeout,
  output logic        busy,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] x;
    logic [7:0] y;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Ready depends only on the registered count, so a pop on the same edge
  // never lets an extra command slip into a full FIFO.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head      = mem[rptr];

  assign alu_begin = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) || !empty;

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_op, cmd_x, cmd_y};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_op      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_timeout <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      // Any END outside WAIT belongs to no live operation (typically a late
      // answer to a timed-out one); flag it and otherwise ignore it.
      if (alu_end && (state != S_WAIT)) proto_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!empty) begin
            alu_op <= head.op;
            alu_x  <= head.x;
            alu_y  <= head.y;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // END has priority over an expiring timeout on the same edge.
          if (alu_end) begin
            res_data    <= alu_out;
            res_op      <= alu_op;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= S_DONE;
          end else if (cnt == LAST_CNT) begin
            res_data    <= '0;
            res_op      <= alu_op;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
